// File: rtl/acc_disp_pkg.sv
// Shared types and constants for the accumulator BCD display.
// Segment codes are active-low and ordered {g,f,e,d,c,b,a}.
package acc_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/acc_bcd_display_seg7_decode.sv
// seg7_decode: one BCD digit to an active-low 7-segment code.
// A blank request, or a non-decimal code, turns every segment off.
module seg7_decode
  import acc_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Map the digit value to its segment pattern.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/acc_bcd_display.sv
// acc_bcd_display: captures the accumulator sum and flags on start,
// converts the sum to BCD by sequential double-dabble (one bit per
// cycle) and drives blanked active-low 7-segment digits plus flag LEDs.
// Optional build macro SIGNED_DISP_EN: treat bin_in as two's complement,
// convert its magnitude and show a minus sign above the leading digit.
module acc_bcd_display
  import acc_disp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  ovf_in,
  input  logic                  co_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   hex_out,
  output logic                  ovf_led,
  output logic                  co_led
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    sreg_q, sreg_d;
  logic [4*DIGITS-1:0] scratch_q, scratch_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_hold_q, ovf_hold_d;
  logic                co_hold_q, co_hold_d;
  logic                neg_hold_q, neg_hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic                ovf_led_q, ovf_led_d;
  logic                co_led_q, co_led_d;

  logic [WIDTH-1:0]    mag_s;
  logic                neg_s;
  logic [4*DIGITS-1:0] adj_s;
  logic [DIGITS-1:0]   shown_s;
  logic [DIGITS-1:0]   minus_s;
  logic                seen_s;
  logic [6:0]          seg_s [DIGITS];
  logic [7*DIGITS-1:0] hex_s;

  // Value to convert: raw input, or its magnitude when signed display is built in.
  always_comb begin
`ifdef SIGNED_DISP_EN
    neg_s = bin_in[WIDTH-1];
    if (neg_s) begin
      mag_s = ~bin_in + WIDTH'(1);
    end else begin
      mag_s = bin_in;
    end
`else
    neg_s = 1'b0;
    mag_s = bin_in;
`endif
  end

  // Double-dabble correction: every scratch digit of 5 or more gets +3.
  always_comb begin
    adj_s = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = scratch_q[4*i +: 4];
      end
    end
  end

  // A digit is shown if it or any digit above it is nonzero; digit 0 always shows.
  always_comb begin
    seen_s  = 1'b0;
    shown_s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if ((scratch_q[4*i +: 4] != 4'd0) || (i == 0)) begin
        seen_s = 1'b1;
      end else begin
        seen_s = seen_s;
      end
      shown_s[i] = seen_s;
    end
  end

  // Minus goes on the first blank digit directly above the leading shown digit.
  always_comb begin
    minus_s = '0;
    for (int i = 1; i < DIGITS; i++) begin
      minus_s[i] = neg_hold_q && !shown_s[i] && shown_s[i-1];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_decode u_dec (
      .bcd   (scratch_q[4*g +: 4]),
      .blank (!shown_s[g]),
      .seg   (seg_s[g])
    );
    assign hex_s[7*g +: 7] = minus_s[g] ? SEG_MINUS : seg_s[g];
  end

  // Next-state and next-output logic of the conversion FSM.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_hold_d = ovf_hold_q;
    co_hold_d  = co_hold_q;
    neg_hold_d = neg_hold_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    hex_d      = hex_q;
    ovf_led_d  = ovf_led_q;
    co_led_d   = co_led_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT;
          sreg_d     = mag_s;
          neg_hold_d = neg_s;
          scratch_d  = '0;
          cnt_d      = CW'(WIDTH);
          ovf_hold_d = ovf_in;
          co_hold_d  = co_in;
          busy_d     = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      SHIFT: begin
        scratch_d = {adj_s[4*DIGITS-2:0], sreg_q[WIDTH-1]};
        sreg_d    = {sreg_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FINISH;
          busy_d  = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
      FINISH: begin
        bcd_d     = scratch_q;
        hex_d     = hex_s;
        ovf_led_d = ovf_hold_q;
        co_led_d  = co_hold_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_hold_q <= 1'b0;
      co_hold_q  <= 1'b0;
      neg_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      hex_q      <= {(7*DIGITS){1'b1}};
      ovf_led_q  <= 1'b0;
      co_led_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_hold_q <= ovf_hold_d;
      co_hold_q  <= co_hold_d;
      neg_hold_q <= neg_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      hex_q      <= hex_d;
      ovf_led_q  <= ovf_led_d;
      co_led_q   <= co_led_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign hex_out = hex_q;
  assign ovf_led = ovf_led_q;
  assign co_led  = co_led_q;

endmodule

// File: tb/tb_acc_bcd_display.sv
// Self-checking bench for acc_bcd_display (WIDTH=8, DIGITS=4).
// Expected values come from a decimal-arithmetic reference model.
module tb_acc_bcd_display;

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b0;
  logic [7:0]  bin_in  = 8'd0;
  logic        ovf_in  = 1'b0;
  logic        co_in   = 1'b0;
  logic        start   = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic [27:0] hex_out;
  logic        ovf_led;
  logic        co_led;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] T_BLANK = 7'b1111111;
  localparam logic [6:0] T_MINUS = 7'b0111111;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  acc_bcd_display #(.WIDTH(8), .DIGITS(4)) dut (
    .clk_sys (clk_sys),
    .rst_sys (rst_sys),
    .bin_in  (bin_in),
    .ovf_in  (ovf_in),
    .co_in   (co_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .hex_out (hex_out),
    .ovf_led (ovf_led),
    .co_led  (co_led)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: displayed magnitude and sign of a raw input.
  function automatic int m_mag(input logic [7:0] v);
`ifdef SIGNED_DISP_EN
    if (v[7]) return 256 - int'(v);
`endif
    return int'(v);
  endfunction

  function automatic bit m_neg(input logic [7:0] v);
`ifdef SIGNED_DISP_EN
    return v[7];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] m_bcd(input logic [7:0] v);
    int m;
    logic [15:0] r;
    m = m_mag(v);
    r[3:0]   = 4'(m % 10);
    r[7:4]   = 4'((m / 10) % 10);
    r[11:8]  = 4'((m / 100) % 10);
    r[15:12] = 4'((m / 1000) % 10);
    return r;
  endfunction

  function automatic logic [27:0] m_hex(input logic [7:0] v);
    int m;
    int d [4];
    int msd;
    logic [27:0] r;
    m = m_mag(v);
    d[0] = m % 10; d[1] = (m / 10) % 10; d[2] = (m / 100) % 10; d[3] = m / 1000;
    msd = 0;
    for (int k = 0; k < 4; k++) if (d[k] != 0) msd = k;
    for (int k = 0; k < 4; k++) begin
      if (k <= msd)                    r[7*k +: 7] = seg_tab[d[k]];
      else if (m_neg(v) && k == msd+1) r[7*k +: 7] = T_MINUS;
      else                             r[7*k +: 7] = T_BLANK;
    end
    return r;
  endfunction

  // Drive one conversion and observe a fixed 16-cycle window after it.
  // Inputs are scrambled after the start cycle; an optional second start
  // is injected at window cycle second_at.
  task automatic run_conv(input logic [7:0] v, input logic ov, input logic c,
                          input int second_at, input logic [7:0] v2,
                          output int done_at, output int ndone, output int nbusy,
                          output logic [15:0] bcd_c, output logic [27:0] hex_c,
                          output logic ovl, output logic col);
    done_at = -1; ndone = 0; nbusy = 0;
    bcd_c = 16'h0; hex_c = 28'h0; ovl = 1'b0; col = 1'b0;
    @(negedge clk_sys);
    bin_in = v; ovf_in = ov; co_in = c; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (done === 1'b1) begin
        ndone++;
        if (done_at < 0) begin
          done_at = n; bcd_c = bcd_out; hex_c = hex_out; ovl = ovf_led; col = co_led;
        end
      end
      if (busy === 1'b1) nbusy++;
      if (n == second_at) begin
        start = 1'b1; bin_in = v2;
      end else begin
        start = 1'b0; bin_in = 8'($urandom); ovf_in = 1'($urandom); co_in = 1'($urandom);
      end
      @(negedge clk_sys);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_sys = 1'b1;
    repeat (2) @(negedge clk_sys);
    rst_sys = 1'b0;
    checks++;
    if ({busy, done, ovf_led, co_led} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, ovf_led, co_led});
    end
    checks++;
    if (bcd_out !== 16'h0000) begin
      errors++; $display("FAIL reset_bcd: got %h want 0000", bcd_out);
    end
    checks++;
    if (hex_out !== {28{1'b1}}) begin
      errors++; $display("FAIL reset_hex: got %h want fffffff", hex_out);
    end
  endtask

  task automatic test_zero();
    int da, nd, nb; logic [15:0] b; logic [27:0] h; logic ol, cl;
    run_conv(8'd0, 1'b0, 1'b0, -1, 8'd0, da, nd, nb, b, h, ol, cl);
    checks++;
    if (da !== 9) begin errors++; $display("FAIL zero_latency: got %0d want 9", da); end
    checks++;
    if (nb !== 8) begin errors++; $display("FAIL zero_busy_cycles: got %0d want 8", nb); end
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", nd); end
    checks++;
    if (b !== 16'h0000) begin errors++; $display("FAIL zero_bcd: got %h want 0000", b); end
    checks++;
    if (h !== {T_BLANK, T_BLANK, T_BLANK, 7'b1000000}) begin
      errors++; $display("FAIL zero_hex: got %h want %h", h, {T_BLANK, T_BLANK, T_BLANK, 7'b1000000});
    end
    checks++;
    if (bcd_out !== b || hex_out !== h) begin
      errors++; $display("FAIL zero_hold: got %h/%h want %h/%h", bcd_out, hex_out, b, h);
    end
  endtask

  task automatic test_max();
    int da, nd, nb; logic [15:0] b, eb; logic [27:0] h, eh;
    logic ol, cl;
`ifdef SIGNED_DISP_EN
    eb = 16'h0001; eh = {T_BLANK, T_BLANK, T_MINUS, 7'b1111001};
`else
    eb = 16'h0255; eh = {T_BLANK, 7'b0100100, 7'b0010010, 7'b0010010};
`endif
    run_conv(8'd255, 1'b0, 1'b1, -1, 8'd0, da, nd, nb, b, h, ol, cl);
    checks++;
    if (b !== eb) begin errors++; $display("FAIL max_bcd: got %h want %h", b, eb); end
    checks++;
    if (h !== eh) begin errors++; $display("FAIL max_hex: got %h want %h", h, eh); end
  endtask

  task automatic test_ignore_start();
    int da, nd, nb; logic [15:0] b; logic [27:0] h; logic ol, cl;
    run_conv(8'd100, 1'b0, 1'b0, 2, 8'd7, da, nd, nb, b, h, ol, cl);
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
    checks++;
    if (b !== 16'h0100) begin errors++; $display("FAIL ignore_bcd: got %h want 0100", b); end
    checks++;
    if (da !== 9) begin errors++; $display("FAIL ignore_latency: got %0d want 9", da); end
  endtask

  task automatic test_flags();
    int da, nd, nb; logic [15:0] b; logic [27:0] h; logic ol, cl;
    run_conv(8'd33, 1'b1, 1'b0, -1, 8'd0, da, nd, nb, b, h, ol, cl);
    checks++;
    if ({ol, cl} !== 2'b10) begin errors++; $display("FAIL flags_10: got %b want 10", {ol, cl}); end
    run_conv(8'd34, 1'b0, 1'b1, -1, 8'd0, da, nd, nb, b, h, ol, cl);
    checks++;
    if ({ol, cl} !== 2'b01) begin errors++; $display("FAIL flags_01: got %b want 01", {ol, cl}); end
    run_conv(8'd35, 1'b1, 1'b1, -1, 8'd0, da, nd, nb, b, h, ol, cl);
    checks++;
    if ({ol, cl} !== 2'b11) begin errors++; $display("FAIL flags_11: got %b want 11", {ol, cl}); end
  endtask

  task automatic test_reset_mid();
    int nd;
    @(negedge clk_sys);
    bin_in = 8'd42; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    repeat (3) @(negedge clk_sys);
    rst_sys = 1'b1;
    @(negedge clk_sys);
    rst_sys = 1'b0;
    checks++;
    if ({busy, done, ovf_led, co_led} !== 4'b0000) begin
      errors++; $display("FAIL midreset_ctrl: got %b want 0000", {busy, done, ovf_led, co_led});
    end
    checks++;
    if (bcd_out !== 16'h0000 || hex_out !== {28{1'b1}}) begin
      errors++; $display("FAIL midreset_outputs: got %h/%h want 0000/fffffff", bcd_out, hex_out);
    end
    nd = 0;
    for (int n = 0; n < 15; n++) begin
      if (done === 1'b1 || busy === 1'b1) nd++;
      @(negedge clk_sys);
    end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL midreset_no_resume: got %0d active cycles want 0", nd); end
  endtask

  task automatic test_fb();
    int da, nd, nb; logic [15:0] b, eb; logic [27:0] h, eh;
    logic ol, cl;
`ifdef SIGNED_DISP_EN
    eb = 16'h0005; eh = {T_BLANK, T_BLANK, 7'b0111111, 7'b0010010};
`else
    eb = 16'h0251; eh = {T_BLANK, 7'b0100100, 7'b0010010, 7'b1111001};
`endif
    run_conv(8'hFB, 1'b0, 1'b0, -1, 8'd0, da, nd, nb, b, h, ol, cl);
    checks++;
    if (b !== eb) begin errors++; $display("FAIL fb_bcd: got %h want %h", b, eb); end
    checks++;
    if (h !== eh) begin errors++; $display("FAIL fb_hex: got %h want %h", h, eh); end
  endtask

  task automatic test_random();
    int da, nd, nb; logic [15:0] b; logic [27:0] h; logic ol, cl;
    logic [7:0] v; logic ov, c;
    for (int t = 0; t < 24; t++) begin
      v = 8'($urandom); ov = 1'($urandom); c = 1'($urandom);
      if (t == 0) v = 8'd9;
      if (t == 1) v = 8'd10;
      if (t == 2) v = 8'd128;
      if (t == 3) v = 8'd99;
      run_conv(v, ov, c, -1, 8'd0, da, nd, nb, b, h, ol, cl);
      checks++;
      if (da !== 9 || nd !== 1) begin
        errors++; $display("FAIL rand_timing v=%0d: got done_at=%0d count=%0d want 9/1", v, da, nd);
      end
      checks++;
      if (b !== m_bcd(v) || h !== m_hex(v) || {ol, cl} !== {ov, c}) begin
        errors++; $display("FAIL rand_result v=%0d: got %h/%h/%b want %h/%h/%b",
                           v, b, h, {ol, cl}, m_bcd(v), m_hex(v), {ov, c});
      end
    end
  endtask

  task automatic test_back_to_back();
    int n; logic [7:0] v1, v2;
    v1 = 8'd57; v2 = 8'd204;
    @(negedge clk_sys);
    bin_in = v1; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk_sys); n++;
    end
    checks++;
    if (n !== 9) begin errors++; $display("FAIL b2b_first_latency: got %0d want 9", n); end
    bin_in = v2; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0; bin_in = 8'd0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk_sys); n++;
    end
    checks++;
    if (n !== 9) begin errors++; $display("FAIL b2b_second_latency: got %0d want 9", n); end
    checks++;
    if (bcd_out !== m_bcd(v2) || hex_out !== m_hex(v2)) begin
      errors++; $display("FAIL b2b_result: got %h/%h want %h/%h", bcd_out, hex_out, m_bcd(v2), m_hex(v2));
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_ignore_start();
    test_flags();
    test_reset_mid();
    test_fb();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_bcd_display.md
Name: acc_bcd_display

Overview:
- Downstream stage of the 8-bit add/subtract accumulator.
- On a start pulse it captures the accumulator sum and its carry/overflow flags.
- It converts the sum to BCD by sequential double-dabble (one bit per cycle).
- It drives active-low 7-segment digits with leading-zero blanking, plus flag LEDs, for the board HEX displays.

Parameters:
- WIDTH, 8, binary input width.
- DIGITS, 4, number of BCD/7-seg digits; must hold ceil(WIDTH*log10(2)) digits plus one sign position.

Ports:
- clk_sys  in  1  system clock, rising edge.
- rst_sys  in  1  synchronous reset, active-high.
- bin_in  in  WIDTH  accumulator sum to display.
- ovf_in  in  1  accumulator overflow flag.
- co_in  in  1  accumulator carry-out flag.
- start  in  1  request conversion; sampled only in IDLE.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when results update.
- bcd_out  out  4*DIGITS  packed BCD; digit 0 is LSBs.
- hex_out  out  7*DIGITS  active-low segments; digit 0 is LSBs; within a digit bit0=a … bit6=g.
- ovf_led  out  1  captured overflow flag.
- co_led  out  1  captured carry flag.

Behaviour:
- Reset (synchronous, active-high, on the clk_sys edge) sets state IDLE and all outputs as follows:
  - busy=0, done=0.
  - bcd_out=0.
  - hex_out all ones (every digit blank).
  - ovf_led=0, co_led=0.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1 captures bin_in into shift register sreg, and ovf_in/co_in into holding flops.
  - Clears the BCD scratch, loads bit counter = WIDTH, goes to SHIFT.
  - busy=1 from the next cycle.
- SHIFT, each cycle:
  - Every scratch digit >=5 gets +3.
  - Then {scratch, sreg} shifts left by one.
  - Counter decrements; on the cycle the counter reaches 0, go to FINISH.
- FINISH:
  - Registers scratch into bcd_out, segment codes into hex_out, captured flags into ovf_led/co_led.
  - done=1 for this single cycle, busy=0; return to IDLE.
- Latency: start sampled at edge T -> done and new outputs visible after edge T+WIDTH+1 (9 cycles for WIDTH=8).
- Outputs hold their values between conversions.
- start while busy or in FINISH is ignored, not queued.
- start back-to-back with done: accepted on the first IDLE cycle after FINISH.
- Inputs are sampled only at start; changes afterwards do not affect the result.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - blank=1111111, minus=0111111.
- Leading-zero blanking: digits above the most significant nonzero digit are blank; digit 0 is always shown. bcd_out itself is not blanked.
- Reset mid-conversion aborts immediately: no done pulse; all outputs return to reset values.

Optional Feature:
- Macro SIGNED_DISP_EN.
- Defined:
  - bin_in is two's complement.
  - If MSB=1, the conversion uses the magnitude (-bin_in as unsigned WIDTH bits; -128 -> 128).
  - The digit immediately above the most significant shown digit displays minus.
  - bcd_out holds the magnitude.
- Undefined: bin_in is unsigned; minus is never shown.

Decomposition:
- Package acc_disp_pkg:
  - state enum (IDLE, SHIFT, FINISH).
  - SEG_BLANK, SEG_MINUS constants, and the ten digit segment constants.
- Sub-module seg7_decode: combinational, 4-bit BCD + blank input -> 7-bit active-low code; instantiated DIGITS times.

Test Plan:
- Reset, then start with bin_in=0 -> done 9 cycles later; bcd_out=0x0000; hex digit0=1000000; digits 1–3 blank; busy high for exactly 8 cycles.
- bin_in=255 -> bcd_out=0x0255; digit2=0100100, digit1=0010010, digit0=0010010; digit3 blank.
- start with bin_in=100, then start with bin_in=7 three cycles later -> second start ignored; result 0x0100; exactly one done pulse.
- Reset asserted 4 cycles into a conversion of 42 -> busy=0, hex_out all blank, bcd_out=0; no done pulse.
- ovf_in=1, co_in=0 at start, toggled afterwards -> after done, ovf_led=1 and co_led=0.
- bin_in=8'hFB:
  - With SIGNED_DISP_EN: bcd_out=0x0005, digit1=0111111, digit0=0010010.
  - Without it: bcd_out=0x0251.
